// File: rtl/fifo_rr_drain.sv
// Round-robin drain of NUM_CH fifo read ports into one valid/ready sink.
// Each grant bursts up to BURST words, one word per ARB -> POP -> OUT pass.
module fifo_rr_drain #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST      = 4,
    parameter int CH_BITS    = 2
) (
    input  logic                         clk,
    input  logic                         clr,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ch_dout,
    input  logic [NUM_CH-1:0]            ch_empty,
    output logic [NUM_CH-1:0]            ch_rd_en,
    input  logic [NUM_CH-1:0]            ch_enable,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [CH_BITS-1:0]           out_chan,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         busy
);

    typedef enum logic [1:0] {ARB, POP, OUT} state_t;

    state_t                  state, state_nx;
    logic [CH_BITS-1:0]      grant, grant_nx, last_grant, last_nx;
    logic [CH_BITS-1:0]      base, pick;
    logic [7:0]              burst_cnt, burst_nx;
    logic [DATA_WIDTH-1:0]   data_nx, head;
    logic [CH_BITS-1:0]      chan_nx;
    logic                    valid_nx;
    logic [NUM_CH-1:0]       elig, grant_oh;
    logic                    found, cont;

    assign elig     = ch_enable & ~ch_empty;
    assign grant_oh = NUM_CH'(1) << grant;
    assign head     = DATA_WIDTH'(ch_dout >> (int'(grant) * DATA_WIDTH));
    assign busy     = (state != ARB);

    // A live burst searches after the current grant so it is checked last.
    assign base = (burst_cnt != 8'd0) ? grant : last_grant;
    assign cont = (burst_cnt != 8'd0) && (burst_cnt < 8'(BURST)) && |(elig & grant_oh);

    // First eligible channel strictly after base, wrapping back to base itself.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (!found && elig[c] && (CH_BITS'(c) > base)) begin
                found = 1'b1;
                pick  = CH_BITS'(c);
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (!found && elig[c] && (CH_BITS'(c) <= base)) begin
                found = 1'b1;
                pick  = CH_BITS'(c);
            end
        end
    end

    always_comb begin
        state_nx = state;
        grant_nx = grant;
        last_nx  = last_grant;
        burst_nx = burst_cnt;
        data_nx  = out_data;
        chan_nx  = out_chan;
        valid_nx = out_valid;
        ch_rd_en = '0;
        case (state)
            ARB: begin
                if (cont) begin
                    state_nx = POP;
                end else begin
                    burst_nx = 8'd0;
                    last_nx  = base;
                    if (found) begin
                        grant_nx = pick;
                        state_nx = POP;
                    end
                end
            end
            POP: begin
                ch_rd_en = grant_oh;
                data_nx  = head;
                chan_nx  = grant;
                valid_nx = 1'b1;
                burst_nx = burst_cnt + 8'd1;
                state_nx = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    valid_nx = 1'b0;
                    state_nx = ARB;
                end
            end
            default: state_nx = ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state      <= ARB;
            grant      <= '0;
            last_grant <= CH_BITS'(NUM_CH - 1);
            burst_cnt  <= 8'd0;
            out_data   <= '0;
            out_chan   <= '0;
            out_valid  <= 1'b0;
        end else begin
            state      <= state_nx;
            grant      <= grant_nx;
            last_grant <= last_nx;
            burst_cnt  <= burst_nx;
            out_data   <= data_nx;
            out_chan   <= chan_nx;
            out_valid  <= valid_nx;
        end
    end

endmodule

// File: tb/tb_fifo_rr_drain.sv
// Bench for fifo_rr_drain: two instances (BURST=4 and BURST=1) fed by fifo models,
// outputs compared to a transaction-level round-robin reference.
module tb_fifo_rr_drain;

    localparam int NCH = 4;
    localparam int DW  = 8;
    localparam int CB  = 2;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    logic [NCH*DW-1:0] ch_dout   [2];
    logic [NCH-1:0]    ch_empty  [2];
    logic [NCH-1:0]    ch_rd_en  [2];
    logic [NCH-1:0]    ch_enable [2];
    logic [DW-1:0]     out_data  [2];
    logic [CB-1:0]     out_chan  [2];
    logic              out_valid [2];
    logic              out_ready [2];
    logic              busy      [2];

    fifo_rr_drain #(.NUM_CH(NCH), .DATA_WIDTH(DW), .BURST(4), .CH_BITS(CB)) u_b4 (
        .clk(clk), .clr(clr), .ch_dout(ch_dout[0]), .ch_empty(ch_empty[0]),
        .ch_rd_en(ch_rd_en[0]), .ch_enable(ch_enable[0]), .out_data(out_data[0]),
        .out_chan(out_chan[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .busy(busy[0]));

    fifo_rr_drain #(.NUM_CH(NCH), .DATA_WIDTH(DW), .BURST(1), .CH_BITS(CB)) u_b1 (
        .clk(clk), .clr(clr), .ch_dout(ch_dout[1]), .ch_empty(ch_empty[1]),
        .ch_rd_en(ch_rd_en[1]), .ch_enable(ch_enable[1]), .out_data(out_data[1]),
        .out_chan(out_chan[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .busy(busy[1]));

    // fifo read-side model: empty and dout registered one edge behind the pointers
    logic [7:0] mem [2][4][256];
    int         wp  [2][4];
    int         rp  [2][4];
    logic [7:0] dq  [2][4];
    logic       eq  [2][4];
    int         popcnt [2][4];
    int         bad_pop = 0, overlap = 0, cyc = 0;

    logic [9:0] got    [2][1024];
    int         hs_cyc [2][1024];
    int         ng     [2];

    for (genvar k = 0; k < 2; k++) begin : g_k
        for (genvar c = 0; c < 4; c++) begin : g_c
            assign ch_dout[k][c*DW +: DW] = dq[k][c];
            assign ch_empty[k][c]         = eq[k][c];
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < 4; c++) begin
                eq[k][c] <= (wp[k][c] == rp[k][c]);
                dq[k][c] <= mem[k][c][rp[k][c][7:0]];
                if (ch_rd_en[k][c]) begin
                    popcnt[k][c]++;
                    if (wp[k][c] == rp[k][c]) bad_pop++;
                    else rp[k][c] <= rp[k][c] + 1;
                end
            end
            if ($countones(ch_rd_en[k]) > 1) overlap++;
            if (!clr && out_valid[k] && out_ready[k] && ng[k] < 1024) begin
                got[k][ng[k]]    = {out_chan[k], out_data[k]};
                hs_cyc[k][ng[k]] = cyc;
                ng[k]++;
            end
        end
    end

    // reference: per-channel queues drained in round-robin bursts
    logic [9:0] expq [2][1024];
    int         ne   [2];
    int         nchk [2];
    int         mrp  [2][4];
    int         mlast[2];
    int         total = 0, bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic load(input int k, input int c, input int n);
        for (int i = 0; i < n; i++) begin
            mem[k][c][wp[k][c][7:0]] = 8'($urandom);
            wp[k][c]++;
        end
    endtask

    task automatic drain(input int k, input logic [3:0] m, input int limit);
        int  taken, g, n, bl;
        bit  f;
        taken = 0;
        bl = (k == 0) ? 4 : 1;
        while (taken < limit) begin
            f = 0;
            g = 0;
            for (int i = 1; i <= 4; i++) begin
                if (!f && m[(mlast[k] + i) % 4] && mrp[k][(mlast[k] + i) % 4] < wp[k][(mlast[k] + i) % 4]) begin
                    f = 1;
                    g = (mlast[k] + i) % 4;
                end
            end
            if (!f) break;
            n = 0;
            while (n < bl && taken < limit && mrp[k][g] < wp[k][g]) begin
                expq[k][ne[k]] = {2'(g), mem[k][g][mrp[k][g][7:0]]};
                ne[k]++;
                mrp[k][g]++;
                n++;
                taken++;
            end
            mlast[k] = g;
        end
    endtask

    task automatic accept(input int k);
        int t;
        t = 0;
        while (!out_valid[k] && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("accept_wait", 32'(out_valid[k]), 32'd1);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        out_ready[k] = 1'b1;
        @(negedge clk);
        out_ready[k] = 1'b0;
    endtask

    task automatic accept_all(input int k);
        int guard;
        guard = 0;
        while (ng[k] < ne[k] && guard < 200) begin
            accept(k);
            guard++;
        end
    endtask

    task automatic run_free(input int k);
        int t;
        t = 0;
        out_ready[k] = 1'b1;
        while (ng[k] < ne[k] && t < 500) begin
            @(negedge clk);
            t++;
        end
        out_ready[k] = 1'b0;
    endtask

    task automatic compare(input int k);
        chk("word_count", ng[k], ne[k]);
        for (int i = nchk[k]; i < ne[k]; i++) chk("word", 32'(got[k][i]), 32'(expq[k][i]));
        nchk[k] = ne[k];
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        mlast[0] = 3;
        mlast[1] = 3;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int           b, pc, st;
    logic [7:0]   hd;
    logic [1:0]   hc;
    logic [3:0]   m [2];
    int           rot_exp [8]  = '{0, 0, 0, 0, 2, 2, 0, 0};
    int           fair_exp [12] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 2, 3, 0};

    initial begin
        clr = 1'b1;
        mlast[0] = 3;
        mlast[1] = 3;
        for (int k = 0; k < 2; k++) begin
            ch_enable[k] = '0;
            out_ready[k] = 1'b0;
        end
        repeat (3) @(negedge clk);

        // reset state
        for (int k = 0; k < 2; k++) begin
            chk("rst_valid", 32'(out_valid[k]), 0);
            chk("rst_data", 32'(out_data[k]), 0);
            chk("rst_chan", 32'(out_chan[k]), 0);
            chk("rst_rd_en", 32'(ch_rd_en[k]), 0);
            chk("rst_busy", 32'(busy[k]), 0);
        end
        clr = 1'b0;
        @(negedge clk);

        // single channel, three words, ready tied high
        load(0, 0, 3);
        repeat (2) @(negedge clk);
        ch_enable[0] = 4'hF;
        b = nchk[0];
        drain(0, 4'hF, 1000);
        run_free(0);
        compare(0);
        chk("spacing1", 32'(hs_cyc[0][b+1] - hs_cyc[0][b]), 3);
        chk("spacing2", 32'(hs_cyc[0][b+2] - hs_cyc[0][b+1]), 3);
        repeat (5) @(negedge clk);
        chk("single_pops", popcnt[0][0], 3);
        chk("single_idle", 32'(busy[0]), 0);

        // rotation with BURST=4 from a fresh reset
        pulse_clr();
        ch_enable[0] = 4'h0;
        load(0, 0, 6);
        load(0, 2, 2);
        repeat (2) @(negedge clk);
        ch_enable[0] = 4'hF;
        b = nchk[0];
        drain(0, 4'hF, 1000);
        run_free(0);
        for (int i = 0; i < 8; i++) chk("rot_chan", 32'(got[0][b+i][9:8]), rot_exp[i]);
        compare(0);

        // backpressure: hold the first word for 10 cycles
        ch_enable[0] = 4'h0;
        load(0, 1, 3);
        repeat (2) @(negedge clk);
        ch_enable[0] = 4'hF;
        drain(0, 4'hF, 1000);
        pc = popcnt[0][0] + popcnt[0][1] + popcnt[0][2] + popcnt[0][3];
        st = 0;
        while (!out_valid[0] && st < 50) begin
            @(negedge clk);
            st++;
        end
        hd = out_data[0];
        hc = out_chan[0];
        chk("bp_first", 32'(hd), 32'(expq[0][nchk[0]][7:0]));
        repeat (10) begin
            @(negedge clk);
            chk("bp_valid", 32'(out_valid[0]), 1);
            chk("bp_data", 32'(out_data[0]), 32'(hd));
            chk("bp_chan", 32'(out_chan[0]), 32'(hc));
            chk("bp_rd_en", 32'(ch_rd_en[0]), 0);
        end
        run_free(0);
        compare(0);
        repeat (4) @(negedge clk);
        chk("bp_pops", popcnt[0][0] + popcnt[0][1] + popcnt[0][2] + popcnt[0][3] - pc, 3);

        // fairness BURST=1, channel 1 masked mid-run
        ch_enable[1] = 4'h0;
        for (int c = 0; c < 4; c++) load(1, c, 5);
        repeat (2) @(negedge clk);
        ch_enable[1] = 4'hF;
        b = nchk[1];
        drain(1, 4'hF, 6);
        for (int i = 0; i < 5; i++) accept(1);
        st = 0;
        while (!out_valid[1] && st < 50) begin
            @(negedge clk);
            st++;
        end
        ch_enable[1] = 4'b1101;
        drain(1, 4'b1101, 1000);
        accept_all(1);
        for (int i = 0; i < 12; i++) chk("fair_chan", 32'(got[1][b+i][9:8]), fair_exp[i]);
        compare(1);
        repeat (3) @(negedge clk);
        ch_enable[1] = 4'hF;
        drain(1, 4'hF, 1000);
        accept_all(1);
        repeat (3) @(negedge clk);
        compare(1);

        // randomized masks, loads and stalls on both instances
        for (int it = 0; it < 8; it++) begin
            for (int k = 0; k < 2; k++) begin
                ch_enable[k] = 4'h0;
                m[k] = 4'($urandom_range(1, 15));
                for (int c = 0; c < 4; c++)
                    if ($urandom_range(0, 2) != 0) load(k, c, $urandom_range(1, 5));
            end
            repeat (2) @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                ch_enable[k] = m[k];
                drain(k, m[k], 1000);
            end
            for (int k = 0; k < 2; k++) accept_all(k);
            repeat (3) @(negedge clk);
            for (int k = 0; k < 2; k++) compare(k);
        end
        for (int k = 0; k < 2; k++) begin
            ch_enable[k] = 4'hF;
            drain(k, 4'hF, 1000);
        end
        for (int k = 0; k < 2; k++) accept_all(k);
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) compare(k);

        // single word: one pop, pointers meet, no re-pop on stale empty
        pc = popcnt[0][3];
        load(0, 3, 1);
        drain(0, 4'hF, 1000);
        run_free(0);
        repeat (6) @(negedge clk);
        compare(0);
        chk("last_pops", popcnt[0][3] - pc, 1);
        chk("last_ptrs", rp[0][3], wp[0][3]);

        // clr while holding a word from ch3: word dropped, ch0 granted next
        load(0, 3, 2);
        st = 0;
        while (!out_valid[0] && st < 50) begin
            @(negedge clk);
            st++;
        end
        chk("clr_pre_chan", 32'(out_chan[0]), 3);
        clr = 1'b1;
        mrp[0][3]++;
        load(0, 0, 2);
        @(negedge clk);
        chk("clr_valid", 32'(out_valid[0]), 0);
        chk("clr_rd_en", 32'(ch_rd_en[0]), 0);
        chk("clr_busy", 32'(busy[0]), 0);
        @(negedge clk);
        clr = 1'b0;
        mlast[0] = 3;
        mlast[1] = 3;
        b = nchk[0];
        drain(0, 4'hF, 1000);
        run_free(0);
        chk("clr_next_chan", 32'(got[0][b][9:8]), 0);
        compare(0);

        chk("pop_on_empty", bad_pop, 0);
        chk("rd_en_overlap", overlap, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_rr_drain.md
Name: fifo_rr_drain

Overview:
- Round-robin scheduler that drains NUM_CH instances of the team's standard fifo into one shared valid/ready sink, such as the uart or host response path.
- Each channel is a fifo read side: dout is always the head word, rd_en pops, and empty is registered one clock behind the pointers.
- The block owns every rd_en. It bursts up to BURST words per grant, then rotates to the next channel.
- It tags each output word with its source channel.

Parameters:
NUM_CH, 4, number of source fifos (2..16)
DATA_WIDTH, 8, word width
BURST, 4, maximum words taken per grant (1..255)
CH_BITS, 2, channel index width; must be at least clog2(NUM_CH) and at least 1

Ports:
clk  in  1  clock
clr  in  1  synchronous active-high reset
ch_dout  in  NUM_CH*DATA_WIDTH  fifo head words; channel i is at bits [i*DATA_WIDTH +: DATA_WIDTH]
ch_empty  in  NUM_CH  fifo empty flags
ch_rd_en  out  NUM_CH  pop strobes, one-hot or zero, combinational from state
ch_enable  in  NUM_CH  per-channel arbitration mask; 0 = channel skipped
out_data  out  DATA_WIDTH  output word (registered)
out_chan  out  CH_BITS  source channel of out_data (registered)
out_valid  out  1  out_data/out_chan valid
out_ready  in  1  sink accepts the word when out_valid && out_ready
busy  out  1  high in POP or OUT state

Behaviour:
- Clock and reset: one clock, clk. Reset is clr, synchronous, active-high.
- Reset values: state=ARB, out_valid=0, out_data=0, out_chan=0, ch_rd_en=0, busy=0, burst_cnt=0, last_grant=NUM_CH-1 (so channel 0 is checked first).
- clr overrides everything in the same edge, including mid-burst. A captured but unaccepted word is dropped, and no further rd_en is issued.
- State ARB:
  - A channel is eligible when ch_enable[i] && !ch_empty[i].
  - Burst continue: if 0 < burst_cnt < BURST and grant is eligible, keep grant and go to POP.
  - Otherwise burst_cnt <= 0. Search round-robin from last_grant+1 (mod NUM_CH), wrapping once. The first eligible channel becomes grant and the state goes to POP.
  - When a grant ends (limit reached, channel emptied or masked), last_grant <= the old grant, so that channel is checked last in the next search.
  - Nothing eligible: stay in ARB. No rd_en is driven in ARB.
- State POP (exactly one cycle):
  - ch_rd_en[grant]=1.
  - On the edge: out_data <= ch_dout[grant], out_chan <= grant, out_valid <= 1, burst_cnt <= burst_cnt+1. Go to OUT.
- State OUT:
  - Hold out_valid, out_data and out_chan stable until out_ready.
  - On handshake: out_valid <= 0, go to ARB.
  - No rd_en in OUT.
- Timing rationale for the mandatory ARB pass:
  - The fifo registers dout and empty one edge after the pointer move.
  - Returning to ARB guarantees ch_empty and ch_dout reflect the pop before the next decision.
  - The block never pops on stale empty.
- Throughput: at most one word per 3 cycles with out_ready tied high. First-word latency is 2 cycles from eligibility seen in ARB to out_valid.
- Masking: a ch_enable change takes effect at the next ARB. Deasserting the granted channel's enable ends its burst there.
- out_ready while out_valid=0 is ignored.
- ch_rd_en is asserted only for a channel observed non-empty in the preceding ARB cycle. The fifo's own rd_en && !empty guard is never relied on.
- burst_cnt is 8 bits. Burst length is exact: BURST=1 gives strict per-word rotation.
- The empty test uses the fifo's registered empty only. A write landing in an empty fifo becomes visible 1 cycle later, and the block tolerates this.

Test Plan:
- Single channel: ch0 holds A1,A2,A3, out_ready=1, BURST=4 -> out_data A1,A2,A3 with out_chan=0 at 3-cycle spacing; then idle; exactly 3 rd_en pulses.
- Rotation: ch0 holds 6 words, ch2 holds 2 words, BURST=4 -> output order ch0×4, ch2×2, ch0×2; rd_en never overlaps.
- Backpressure: out_ready=0 for 10 cycles after the first word -> out_valid, out_data and out_chan stable; no rd_en during the stall; no word lost or duplicated.
- Fairness/wrap: all 4 channels continuously non-empty, BURST=1 -> grants 0,1,2,3,0,1,…; ch_enable[1]=0 mid-run -> sequence becomes 0,2,3,0.
- Last-word empty timing: a fifo with exactly 1 word -> one pop only; ARB sees empty=1 and does not re-pop, and the fifo rdptr equals wrptr afterwards.
- clr mid-OUT with out_ready=0 -> next cycle out_valid=0, ch_rd_en=0, state ARB; the next grant is channel 0 even if ch3 was active.
